shared_reg_write_arbiter: RTL and testbench

//  Single legal writer for a design-global register that several submodule instances must update.

---
 rtl/shared_reg_arb_pkg.sv | 14 +
 rtl/shared_reg_write_arbiter_rr_pick.sv | 34 +++
 rtl/shared_reg_write_arbiter.sv | 105 ++++++++++
 tb/tb_shared_reg_write_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arb_pkg.sv
// Shared types and helpers for the shared-register write arbiter.
package shared_reg_arb_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Index width for a requester count; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above
// i_ptr, wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_j;

    always_comb begin
        // NOTE: every output gets a default before the search so no path
        // leaves a value unassigned and no latch is inferred.
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/shared_reg_write_arbiter.sv
// Single legal writer for a design-global register: round-robin arbitration
// among requesters, optional ownership lock, saturating conflict counter.
module shared_reg_write_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int              NUM_REQ   = 2,
    parameter int              DATA_W    = 1,
    parameter int              CNT_W     = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int             IW        = idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         q,
    output logic [IW-1:0]             q_owner,
    output logic                      q_wr,
    input  logic                      clr_cnt,
    output logic [CNT_W-1:0]          conflict_cnt
);

    arb_state_t        r_state;
    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     r_owner;
    logic [DATA_W-1:0] r_q;
    logic              r_q_wr;
    logic [CNT_W-1:0]  r_cnt;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_wr_idx;
    logic [IW-1:0]      w_next_ptr;
    logic               w_wr;
    logic               w_conflict;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // While locked only the owner can be granted; r_owner is also the last
    // writer, so it serves as both lock owner and q_owner.
    always_comb begin
        w_grant  = '0;
        w_wr_idx = r_owner;
        if (!rst) begin
            if (r_state == LOCKED) begin
                w_grant[r_owner] = req[r_owner];
            end else if (w_pick_any) begin
                w_grant  = w_pick_grant;
                w_wr_idx = w_pick_idx;
            end
        end
    end

    assign w_wr       = |(w_grant & req);
    assign w_conflict = (r_state == ARB) && ($countones(req) >= 2);
    assign w_next_ptr = (w_wr_idx == IW'(NUM_REQ - 1)) ? '0 : w_wr_idx + 1'b1;

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state  <= ARB;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_q      <= RESET_VAL;
            r_q_wr   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_q_wr <= w_wr;
            if (w_wr) begin
                r_q      <= wdata[w_wr_idx*DATA_W +: DATA_W];
                r_owner  <= w_wr_idx;
                r_rr_ptr <= w_next_ptr;
                r_state  <= lock[w_wr_idx] ? LOCKED : ARB;
            end else if (r_state == LOCKED) begin
                r_state <= ARB;
            end
            if (clr_cnt) begin
                r_cnt <= '0;
            end else if (w_conflict && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign grant        = w_grant;
    assign q            = r_q;
    assign q_owner      = r_owner;
    assign q_wr         = r_q_wr;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_shared_reg_write_arbiter.sv
// Self-checking bench: directed scenarios then random traffic on a 2-slot
// and a 3-slot instance, compared against a behavioural model.
module tb_shared_reg_write_arbiter;

    typedef struct {
        int n;
        int dw;
        int cmax;
        int rv;
        bit locked;
        int owner;
        int ptr;
        int q;
        bit q_wr;
        int cnt;
    } model_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_cnt;

    logic [1:0]  req_a, lock_a, wdata_a, grant_a;
    logic        q_a, owner_a, q_wr_a;
    logic [7:0]  cnt_a;

    logic [2:0]  req_b, lock_b, grant_b;
    logic [11:0] wdata_b;
    logic [3:0]  q_b;
    logic [1:0]  owner_b, cnt_b;
    logic        q_wr_b;

    int checks = 0;
    int errors = 0;
    model_t ma, mb;

    always #5 clk = ~clk;

    shared_reg_write_arbiter #(
        .NUM_REQ(2), .DATA_W(1), .CNT_W(8), .RESET_VAL(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .lock(lock_a), .wdata(wdata_a),
        .grant(grant_a), .q(q_a), .q_owner(owner_a), .q_wr(q_wr_a),
        .clr_cnt(clr_cnt), .conflict_cnt(cnt_a)
    );

    shared_reg_write_arbiter #(
        .NUM_REQ(3), .DATA_W(4), .CNT_W(2), .RESET_VAL(4'h5)
    ) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .lock(lock_b), .wdata(wdata_b),
        .grant(grant_b), .q(q_b), .q_owner(owner_b), .q_wr(q_wr_b),
        .clr_cnt(clr_cnt), .conflict_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which slot the spec's rules grant this cycle, -1 for none.
    function automatic int m_pick(input model_t m, input int reqv);
        if (m.locked) return ((reqv >> m.owner) & 1) != 0 ? m.owner : -1;
        for (int k = 0; k < m.n; k++) begin
            int j;
            j = (m.ptr + k) % m.n;
            if (((reqv >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    function automatic model_t m_step(input model_t m, input bit r, input bit clr,
                                      input int reqv, input int lockv, input int wd);
        model_t nx;
        int g;
        int pc;
        nx = m;
        if (r) begin
            nx.locked = 0; nx.owner = 0; nx.ptr = 0;
            nx.q = m.rv; nx.q_wr = 0; nx.cnt = 0;
            return nx;
        end
        g  = m_pick(m, reqv);
        pc = 0;
        for (int i = 0; i < m.n; i++) pc += (reqv >> i) & 1;
        if (clr) nx.cnt = 0;
        else if (!m.locked && pc >= 2 && m.cnt < m.cmax) nx.cnt = m.cnt + 1;
        if (g >= 0) begin
            nx.q      = (wd >> (g * m.dw)) & ((1 << m.dw) - 1);
            nx.owner  = g;
            nx.q_wr   = 1;
            nx.ptr    = (g + 1) % m.n;
            nx.locked = ((lockv >> g) & 1) != 0;
        end else begin
            nx.q_wr   = 0;
            nx.locked = 0;
        end
        return nx;
    endfunction

    // One clock: check grants before the edge, advance models, check registers after.
    task automatic step();
        int ga;
        int gb;
        #1;
        ga = rst ? -1 : m_pick(ma, int'(req_a));
        gb = rst ? -1 : m_pick(mb, int'(req_b));
        check("grant_a", 32'(grant_a), (ga < 0) ? 0 : (1 << ga));
        check("grant_b", 32'(grant_b), (gb < 0) ? 0 : (1 << gb));
        @(posedge clk);
        ma = m_step(ma, rst, clr_cnt, int'(req_a), int'(lock_a), int'(wdata_a));
        mb = m_step(mb, rst, clr_cnt, int'(req_b), int'(lock_b), int'(wdata_b));
        @(negedge clk);
        check("q_a",     32'(q_a),     ma.q);
        check("owner_a", 32'(owner_a), ma.owner);
        check("q_wr_a",  32'(q_wr_a),  32'(ma.q_wr));
        check("cnt_a",   32'(cnt_a),   ma.cnt);
        check("q_b",     32'(q_b),     mb.q);
        check("owner_b", 32'(owner_b), mb.owner);
        check("q_wr_b",  32'(q_wr_b),  32'(mb.q_wr));
        check("cnt_b",   32'(cnt_b),   mb.cnt);
    endtask

    task automatic set_a(input logic [1:0] r, input logic [1:0] l, input logic [1:0] d);
        req_a = r; lock_a = l; wdata_a = d;
    endtask

    initial begin
        ma = '{n:2, dw:1, cmax:255, rv:0, locked:0, owner:0, ptr:0, q:0, q_wr:0, cnt:0};
        mb = '{n:3, dw:4, cmax:3,   rv:5, locked:0, owner:0, ptr:0, q:5, q_wr:0, cnt:0};
        rst = 1'b1; clr_cnt = 1'b0;
        set_a(2'b00, 2'b00, 2'b00);
        req_b = '0; lock_b = '0; wdata_b = '0;

        // Reset for two cycles, then idle.
        step(); step();
        rst = 1'b0;
        step();
        check("rst_q_a",     32'(q_a),     0);
        check("rst_cnt_a",   32'(cnt_a),   0);
        check("rst_owner_a", 32'(owner_a), 0);
        check("rst_q_b",     32'(q_b),     5);

        // Both requesting: alternating grants, every edge a conflict.
        set_a(2'b11, 2'b00, 2'b10);
        repeat (4) step();
        check("conflict4", 32'(cnt_a), 4);

        // Slot 0 locks for a burst while slot 1 waits.
        set_a(2'b11, 2'b01, 2'b10);
        step(); step();
        lock_a = 2'b00;
        step();
        check("lock_cnt", 32'(cnt_a), 5);
        step();
        check("after_lock_owner", 32'(owner_a), 1);

        // Locked owner drops its request: no write, slot 1 next.
        set_a(2'b01, 2'b01, 2'b01);
        step();
        set_a(2'b10, 2'b00, 2'b10);
        step();
        check("drop_no_wr", 32'(q_wr_a), 0);
        step();

        // Saturating counter on the 3-slot instance, then clear wins.
        set_a(2'b00, 2'b00, 2'b00);
        req_b = 3'b111; lock_b = 3'b000;
        for (int i = 0; i < 5; i++) begin
            wdata_b = 12'($urandom);
            step();
        end
        check("sat3", 32'(cnt_b), 3);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("clr_wins", 32'(cnt_b), 0);
        req_b = '0;

        // Reset while locked: no write at that edge, arbitration restarts at slot 0.
        set_a(2'b01, 2'b01, 2'b00);
        step();
        set_a(2'b01, 2'b01, 2'b11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_lock_q", 32'(q_a), 0);
        set_a(2'b11, 2'b00, 2'b11);
        step();
        check("rst_lock_grant_owner", 32'(owner_a), 0);

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            req_a   = 2'($urandom);
            lock_a  = 2'($urandom);
            wdata_a = 2'($urandom);
            req_b   = 3'($urandom);
            lock_b  = 3'($urandom);
            wdata_b = 12'($urandom);
            clr_cnt = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
